// File: rtl/core_io_responder.sv
// Bus-side responder for the 4-cycle core: feeds in_bus from a host FIFO on LOADs and
// captures out_bus into a holding register on STOREs. Optional statistics: CORE_IO_STATS_EN.
module core_io_responder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic [31:0]      out_bus,
  output logic [31:0]      in_bus,
  input  logic             host_in_valid,
  input  logic [31:0]      host_in_data,
  output logic             host_in_ready,
  output logic             host_out_valid,
  output logic [31:0]      host_out_data,
  input  logic             host_out_ready,
  output logic             underrun,
  output logic             overflow,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [6:0] OP_LOAD  = 7'b0001000;
  localparam logic [6:0] OP_STORE = 7'b0001001;

  logic [1:0]    ph;
  logic          pend_ld, pend_st;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic unused_inst;
  assign unused_inst = ^inst[31:7];

  logic dec_edge, dec_ld, dec_st, ld_edge, st_edge, push, pop, hs, ovf_set, und_set;

  assign dec_edge = (ph == 2'd0);
  assign dec_ld   = dec_edge && (inst[6:0] == OP_LOAD);
  assign dec_st   = dec_edge && (inst[6:0] == OP_STORE);
  assign ld_edge  = (ph == 2'd1) && pend_ld;
  assign st_edge  = (ph == 2'd3) && pend_st;

  // Fullness is judged on the pre-edge count, so a same-edge pop never frees a slot for a push.
  assign host_in_ready = (count != FULL);
  assign push    = host_in_valid && host_in_ready;
  assign pop     = ld_edge && (count != '0);
  assign und_set = ld_edge && (count == '0);
  assign hs      = host_out_valid && host_out_ready;
  assign ovf_set = st_edge && host_out_valid && !hs;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph             <= 2'd0;
      pend_ld        <= 1'b0;
      pend_st        <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      in_bus         <= '0;
      host_out_valid <= 1'b0;
      host_out_data  <= '0;
      underrun       <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      ph <= ph + 2'd1;
      if (dec_edge) begin
        pend_ld <= dec_ld;
        pend_st <= dec_st;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        in_bus <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A handshake on the capture edge frees the register before the new word lands.
      if (st_edge && (!host_out_valid || hs)) begin
        host_out_data  <= out_bus;
        host_out_valid <= 1'b1;
      end else if (hs) begin
        host_out_valid <= 1'b0;
      end
      if (und_set)        underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

`ifdef CORE_IO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (dec_ld && (load_count != '1))  load_count  <= load_count + CNT_W'(1);
      if (dec_st && (store_count != '1)) store_count <= store_count + CNT_W'(1);
    end
  end
`else
  assign load_count  = '0;
  assign store_count = '0;
`endif

endmodule
